// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Passive protocol checker for a six-lamp intersection controller.
//            Decodes the current phase from the lamp vector and checks lamp
//            encoding, NS/EW conflict, phase ordering and per-phase dwell
//            measured in 1 Hz ticks.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            tick_1hz              - one-clk 1 Hz pulse shared with controller
//            ns_g/ns_y/ns_r        - NS lamps under observation
//            ew_g/ew_y/ew_r        - EW lamps under observation
//            phase[1:0]            - last legal phase (0 NS_G,1 NS_Y,2 EW_G,3 EW_Y)
//            locked                - a legal transition seen since reset
//            err / err_code[2:0]   - sticky error flag / first violation code
//            err_pulse             - one-cycle pulse per violating sample
//            cycle_count[15:0]     - saturating count of EW_Y->NS_G while locked
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
  parameter int G_TICKS = 5,
  parameter int Y_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        ns_g,
  input  logic        ns_y,
  input  logic        ns_r,
  input  logic        ew_g,
  input  logic        ew_y,
  input  logic        ew_r,
  output logic [1:0]  phase,
  output logic        locked,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        err_pulse,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    PH_NS_G = 2'd0,
    PH_NS_Y = 2'd1,
    PH_EW_G = 2'd2,
    PH_EW_Y = 2'd3
  } phase_t;

  localparam int MAX_TICKS = (G_TICKS > Y_TICKS) ? G_TICKS : Y_TICKS;
  // Dwell saturates at limit+1, so room is needed for MAX_TICKS+1.
  localparam int DW = $clog2(MAX_TICKS + 2);
  localparam logic [DW-1:0] G_LIM = DW'(G_TICKS);
  localparam logic [DW-1:0] Y_LIM = DW'(Y_TICKS);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CONFLICT = 3'd1;
  localparam logic [2:0] ERR_ENCODING = 3'd2;
  localparam logic [2:0] ERR_SEQUENCE = 3'd3;
  localparam logic [2:0] ERR_SHORT    = 3'd4;
  localparam logic [2:0] ERR_OVERSTAY = 3'd5;

  phase_t          phase_q, phase_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            locked_q, locked_d;
  logic            first_q, first_d;
  logic            err_q, err_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            err_pulse_q, err_pulse_d;
  logic [15:0]     cycle_q, cycle_d;

  // Decode of the sampled lamp vector
  logic [5:0]      lamps;
  logic            conflict;
  logic            legal;
  phase_t          dec_phase;

  always_comb begin
    lamps     = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
    conflict  = !ns_r && !ew_r;
    legal     = 1'b1;
    dec_phase = PH_NS_G;
    case (lamps)
      6'b100001: dec_phase = PH_NS_G;
      6'b010001: dec_phase = PH_NS_Y;
      6'b001100: dec_phase = PH_EW_G;
      6'b001010: dec_phase = PH_EW_Y;
      default:   legal     = 1'b0;
    endcase
  end

  // Checking and next-state logic
  logic [DW-1:0] limit_held;
  phase_t        succ_phase;
  logic [2:0]    code;

  always_comb begin
    phase_d    = phase_q;
    dwell_d    = dwell_q;
    locked_d   = locked_q;
    first_d    = first_q;
    cycle_d    = cycle_q;
    code       = ERR_NONE;
    limit_held = (phase_q == PH_NS_G || phase_q == PH_EW_G) ? G_LIM : Y_LIM;
    succ_phase = phase_t'(phase_q + 2'd1);

    // Illegal samples hold all tracking state and ignore the tick.
    if (conflict) begin
      code = ERR_CONFLICT;
    end else if (!legal) begin
      code = ERR_ENCODING;
    end else begin
      first_d = 1'b0;
      if (dec_phase == phase_q) begin
        if (tick_1hz) begin
          if (locked_q && dwell_q == limit_held) begin
            code = ERR_OVERSTAY;
          end
          if (dwell_q < limit_held + DW'(1)) begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end else begin
        // Any phase change restarts dwell; a coincident tick counts
        // towards the new phase.
        phase_d = dec_phase;
        dwell_d = tick_1hz ? DW'(1) : '0;
        if (!first_q) begin
          if (dec_phase != succ_phase) begin
            code = ERR_SEQUENCE;
          end else begin
            // The phase in force at lock time may have been partial,
            // so SHORT only applies once already locked.
            if (locked_q && dwell_q < limit_held) begin
              code = ERR_SHORT;
            end
            locked_d = 1'b1;
            if (phase_q == PH_EW_Y && cycle_q != 16'hFFFF) begin
              cycle_d = cycle_q + 16'd1;
            end
          end
        end
      end
    end

    err_pulse_d = (code != ERR_NONE);
    err_d       = err_q;
    err_code_d  = err_code_q;
    if (code != ERR_NONE && !err_q) begin
      err_d      = 1'b1;
      err_code_d = code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PH_NS_G;
      dwell_q     <= '0;
      locked_q    <= 1'b0;
      first_q     <= 1'b1;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_pulse_q <= 1'b0;
      cycle_q     <= 16'd0;
    end else begin
      phase_q     <= phase_d;
      dwell_q     <= dwell_d;
      locked_q    <= locked_d;
      first_q     <= first_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_pulse_q <= err_pulse_d;
      cycle_q     <= cycle_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign err_pulse   = err_pulse_q;
  assign cycle_count = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_monitor
// Purpose  : Directed self-checking bench for traffic_light_monitor with the
//            default G_TICKS=5 / Y_TICKS=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

  localparam logic [5:0] V_NSG  = 6'b100001;
  localparam logic [5:0] V_NSY  = 6'b010001;
  localparam logic [5:0] V_EWG  = 6'b001100;
  localparam logic [5:0] V_EWY  = 6'b001010;
  localparam logic [5:0] V_CONF = 6'b100100; // ns_g + ew_g, no reds
  localparam logic [5:0] V_ALLR = 6'b001001; // both reds only

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        ns_g = 1'b0, ns_y = 1'b0, ns_r = 1'b1;
  logic        ew_g = 1'b0, ew_y = 1'b0, ew_r = 1'b1;
  logic [1:0]  phase;
  logic        locked;
  logic        err;
  logic [2:0]  err_code;
  logic        err_pulse;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;

  traffic_light_monitor #(.G_TICKS(5), .Y_TICKS(2)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .phase(phase), .locked(locked), .err(err), .err_code(err_code),
    .err_pulse(err_pulse), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Apply one sample, let it be clocked, then observe 1 time unit later.
  task automatic drive(input logic [5:0] v, input logic t);
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = v;
    tick_1hz = t;
    @(posedge clk);
    #1;
    if (err_pulse === 1'b1) pulses_seen++;
  endtask

  // Compliant controller phase: n ticks, each preceded by one idle clk.
  task automatic run_phase(input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      drive(v, 1'b0);
      drive(v, 1'b1);
    end
  endtask

  // Reset, then NS_G(5) and NS_Y(2): leaves the monitor locked in NS_Y.
  task automatic bring_up();
    reset = 1'b1;
    drive(V_NSG, 1'b0);
    reset = 1'b0;
    run_phase(V_NSG, 5);
    run_phase(V_NSY, 2);
    pulses_seen = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(V_NSG, 1'b0);
    drive(V_CONF, 1'b1);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b exp 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
    checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", err_code); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b exp 0", err_pulse); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_cycles got %0d exp 0", cycle_count); end
  endtask

  task automatic test_compliant();
    reset = 1'b0;
    pulses_seen = 0;
    run_phase(V_NSG, 5);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL compliant_prelock got %0b exp 0", locked); end
    drive(V_NSY, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL compliant_lock got %0b exp 1", locked); end
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL compliant_phase_nsy got %0d exp 1", phase); end
    run_phase(V_NSY, 2);
    for (int c = 0; c < 3; c++) begin
      run_phase(V_EWG, 5);
      run_phase(V_EWY, 2);
      run_phase(V_NSG, 5);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL compliant_err cycle %0d got %0b exp 0", c, err); end
      if (c < 2) run_phase(V_NSY, 2);
    end
    checks++; if (cycle_count !== 16'd3) begin errors++; $display("FAIL compliant_cycles got %0d exp 3", cycle_count); end
    checks++; if (pulses_seen !== 0) begin errors++; $display("FAIL compliant_pulses got %0d exp 0", pulses_seen); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL compliant_phase_end got %0d exp 0", phase); end
  endtask

  // Continues from test_compliant: locked in NS_G with dwell at its limit.
  task automatic test_conflict();
    drive(V_CONF, 1'b1);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL conflict_pulse got %0b exp 1", err_pulse); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL conflict_err got %0b exp 1", err); end
    checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL conflict_code got %0d exp 1", err_code); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL conflict_phase got %0d exp 0", phase); end
    drive(V_NSG, 1'b0);
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL conflict_pulse_end got %0b exp 0", err_pulse); end
    // The tick during the conflict must not have counted: this one overstays.
    drive(V_NSG, 1'b1);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL conflict_tick_ignored got %0b exp 1", err_pulse); end
    checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL conflict_code_sticky got %0d exp 1", err_code); end
  endtask

  task automatic test_sequence();
    bring_up();
    run_phase(V_EWG, 5);
    run_phase(V_EWY, 2);
    run_phase(V_NSG, 2);
    drive(V_EWG, 1'b0);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL seq_pulse got %0b exp 1", err_pulse); end
    checks++; if (err_code !== 3'd3) begin errors++; $display("FAIL seq_code got %0d exp 3", err_code); end
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL seq_phase got %0d exp 2", phase); end
    checks++; if (cycle_count !== 16'd1) begin errors++; $display("FAIL seq_cycles got %0d exp 1", cycle_count); end
    pulses_seen = 0;
    run_phase(V_EWG, 5);
    run_phase(V_EWY, 2);
    drive(V_NSG, 1'b0);
    checks++; if (pulses_seen !== 0) begin errors++; $display("FAIL seq_resync_pulses got %0d exp 0", pulses_seen); end
    checks++; if (cycle_count !== 16'd2) begin errors++; $display("FAIL seq_resync_cycles got %0d exp 2", cycle_count); end
  endtask

  task automatic test_overstay();
    bring_up();
    drive(V_NSY, 1'b0);
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL over_idle_pulse got %0b exp 0", err_pulse); end
    drive(V_NSY, 1'b1);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL over_pulse got %0b exp 1", err_pulse); end
    checks++; if (err_code !== 3'd5) begin errors++; $display("FAIL over_code got %0d exp 5", err_code); end
    drive(V_NSY, 1'b1);
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL over_saturated_pulse got %0b exp 0", err_pulse); end
  endtask

  task automatic test_short();
    bring_up();
    run_phase(V_EWG, 4);
    drive(V_EWY, 1'b0);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL short_pulse got %0b exp 1", err_pulse); end
    checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL short_code got %0d exp 4", err_code); end
    checks++; if (phase !== 2'd3) begin errors++; $display("FAIL short_phase got %0d exp 3", phase); end
    pulses_seen = 0;
    run_phase(V_EWY, 2);
    run_phase(V_NSG, 2);
    checks++; if (pulses_seen !== 0) begin errors++; $display("FAIL short_after_pulses got %0d exp 0", pulses_seen); end
    drive(V_EWY, 1'b0);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL short_seq_pulse got %0b exp 1", err_pulse); end
    checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL short_code_sticky got %0d exp 4", err_code); end
  endtask

  task automatic test_reset_mid();
    bring_up();
    run_phase(V_EWG, 2);
    drive(V_ALLR, 1'b0);
    checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL mid_enc_code got %0d exp 2", err_code); end
    drive(V_EWG, 1'b1);
    // Reset together with a conflicting vector: reset wins.
    reset = 1'b1;
    drive(V_CONF, 1'b0);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL mid_phase got %0d exp 0", phase); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got %0b exp 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %0b exp 0", err); end
    checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL mid_code got %0d exp 0", err_code); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL mid_pulse got %0b exp 0", err_pulse); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL mid_cycles got %0d exp 0", cycle_count); end
    reset = 1'b0;
    drive(V_EWG, 1'b0);
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL mid_adopt_phase got %0d exp 2", phase); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_adopt_err got %0b exp 0", err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_adopt_locked got %0b exp 0", locked); end
    run_phase(V_EWG, 2);
    drive(V_EWY, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_relock got %0b exp 1", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_relock_err got %0b exp 0", err); end
    run_phase(V_EWY, 2);
    drive(V_NSG, 1'b0);
    checks++; if (cycle_count !== 16'd1) begin errors++; $display("FAIL mid_cycles_after got %0d exp 1", cycle_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_final_err got %0b exp 0", err); end
  endtask

  initial begin
    test_reset();
    test_compliant();
    test_conflict();
    test_sequence();
    test_overstay();
    test_short();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

- Passive protocol checker on the six-lamp intersection interface.
- Samples the lamp outputs and the shared 1 Hz tick, decodes the current phase, and checks:
  - lamp encoding;
  - NS/EW conflict;
  - phase ordering;
  - per-phase dwell in ticks.
- Reports a sticky first-error code, a per-violation pulse, lock status and a completed-cycle count.
- Sits beside the light controller in the intersection subsystem and in its testbenches; drives nothing back into the controller.

## Interface
Parameters:
- G_TICKS, 5, tick pulses a green phase must last
- Y_TICKS, 2, tick pulses a yellow phase must last

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- tick_1hz  in  1  one-clk-wide 1 Hz pulse, same net the controller uses
- ns_g, ns_y, ns_r  in  1 each  NS lamps under observation
- ew_g, ew_y, ew_r  in  1 each  EW lamps under observation
- phase  out  2  last legal decoded phase: 0 NS_G, 1 NS_Y, 2 EW_G, 3 EW_Y
- locked  out  1  a legal phase transition has been observed since reset
- err  out  1  sticky; any violation since reset
- err_code  out  3  code of the first violation since reset (0 = none)
- err_pulse  out  1  one-cycle pulse per violating sample
- cycle_count  out  16  completed EW_Y->NS_G transitions while locked; saturates at 16'hFFFF

## Operation
- Legal lamp vectors; each decodes to one phase:
  - NS_G = ns_g & ew_r
  - NS_Y = ns_y & ew_r
  - EW_G = ew_g & ns_r
  - EW_Y = ew_y & ns_r
  - All other lamps in each vector are 0.
- Violation codes, checked every clk on the sampled inputs:
  - 1 CONFLICT: neither ns_r nor ew_r asserted.
  - 2 ENCODING: not CONFLICT, and the vector is not one of the four legal ones.
  - 3 SEQUENCE: legal phase differs from the held phase and is not its successor. Successor order is NS_G->NS_Y->EW_G->EW_Y->NS_G.
  - 4 SHORT: legal successor transition while locked, with dwell count below the phase limit. Limit is G_TICKS for greens, Y_TICKS for yellows.
  - 5 OVERSTAY: tick sampled in a legal cycle whose phase equals the held phase, locked, and dwell count already equals the limit.
- Priority if several codes apply in one sample: 1 > 2 > 3 > 4 > 5. Only one code is reported per sample.
- Dwell counter:
  - Increments on each tick sampled while the legal decoded phase equals the held phase.
  - Clears to 0 on any phase change, whether legal or SEQUENCE.
  - Saturates at limit+1.
  - Width is sufficient for max(G_TICKS, Y_TICKS)+1.
- Illegal samples (codes 1, 2):
  - phase, dwell counter and locked hold.
  - Ticks in those cycles are ignored.
  - The next legal sample is compared against the held phase.
- Lock:
  - First legal successor transition after reset sets locked.
  - SHORT is not checked on that transition, because the first phase may be partial.
  - OVERSTAY is not checked before lock.
  - locked stays 1 until reset.
- Phase after reset:
  - Reset loads phase = NS_G.
  - The first legal sample is always adopted without a SEQUENCE check.
  - A SEQUENCE violation still adopts the new phase, so the monitor resynchronises.
- Errors:
  - err and err_code latch on the first violation only; later violations pulse err_pulse but do not change err_code.
  - Checking continues after an error.
- cycle_count increments on each legal EW_Y->NS_G transition seen while locked, including the locking transition itself.

## Timing
- All outputs registered. Violation or transition in a sample is visible on outputs at the next clk edge (latency 1).
- Reset values:
  - phase = 0
  - locked = 0
  - err = 0
  - err_code = 0
  - err_pulse = 0
  - cycle_count = 0
  - dwell counter = 0
  - internal "first sample" flag = 1
- Reset mid-operation: all state returns to reset values on that edge. The next phase is again adopted without checks.
- Controller timing compliance:
  - The controller changes lamps on the edge that samples its terminal tick. The monitor therefore sees exactly G_TICKS (or Y_TICKS) ticks in a phase before the new vector appears.
  - A tick coinciding with the phase-change sample belongs to the new phase (dwell = 1).
- Simultaneous reset and violation: reset wins; no error recorded.

## Test plan
- Compliant controller with defaults, 3 full cycles from reset:
  - locked rises 1 clk after the first NS_G->NS_Y change.
  - cycle_count = 3.
  - err = 0 throughout.
- Force ns_g=1, ew_g=1, both reds 0 for one cycle:
  - err_pulse high for 1 clk, err = 1, err_code = 1.
  - phase unchanged.
- While locked in NS_G, jump to EW_G:
  - err_code = 3, phase = 2.
  - Dwell restarts; subsequent compliant EW_G/EW_Y cause no new pulses.
- Locked, NS_Y held through a 3rd tick:
  - err_pulse on that tick sample, err_code = 5.
- Locked, EW_G ends after 4 ticks:
  - err_code = 4.
  - A later SEQUENCE violation pulses err_pulse but err_code stays 4.
- Assert reset mid-EW_G with err = 1:
  - All outputs return to reset values next edge.
  - The monitor relocks on the next legal transition.
